alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised multi-cycle successor to the single-cycle 64-bit ALU, used by the planned multi-cycle datapath.
- Keeps the existing ALUControl encodings for AND, OR, ADD, SUB and PASS B.
- Adds an iterative multiply and unsigned divide, full NZCV flags, and a start/busy/done handshake.
- All results are registered; the datapath stalls while busy=1.

Parameters:
N, 64, operand/result width (N >= 4)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  launch operation; sampled only when busy=0
a  input  N  operand A
b  input  N  operand B
ALUControl  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS B, 1000 MUL (low N bits), 1010 UDIV
busy  output  1  operation in progress
done  output  1  one-cycle pulse when result/flags are updated
result  output  N  registered result, held until next done
zero  output  1  result == 0
negative  output  1  result[N-1]
carry  output  1  ADD carry-out / SUB no-borrow; 0 for other ops
overflow  output  1  signed overflow for ADD/SUB; 0 for other ops

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy, done, result, negative, carry, overflow = 0; zero = 1.
- Operands and opcode are captured at start; later input changes have no effect on the running operation.
- States: IDLE, MUL, DIV, DONE.
  - IDLE, start=1, single-cycle op: compute, go to DONE. done=1 the next cycle (latency 1).
  - IDLE, start=1, MUL or UDIV: load working registers, counter=N, busy=1, go to MUL/DIV.
  - MUL: shift-add, one multiplier bit per cycle, low N bits kept. After N iterations go to DONE.
  - DIV: restoring divide, one quotient bit per cycle. After N iterations go to DONE.
  - Multi-cycle latency: done asserts exactly N+1 cycles after the start cycle.
  - DONE: write result and flags, done=1 for one cycle, busy=0, return to IDLE.
  - A start in the DONE cycle is ignored; start is accepted again in IDLE.
- start while busy=1: ignored. No queueing; the operation in flight is unaffected.
- Divide by zero: result=0, zero=1, latency still N+1. Bypassing the iteration is not permitted.
- Unused opcodes: result=0, flags from the result rule, latency 1.
- Arithmetic (modulo 2^N):
  - ADD: carry = bit N of a+b; overflow = (a[N-1]==b[N-1]) && (result[N-1]!=a[N-1]).
  - SUB: computed as a+~b+1; carry = bit N; overflow = (a[N-1]!=b[N-1]) && (result[N-1]!=a[N-1]).
- Flags always describe the registered result. zero and negative apply to all ops.
- Reset mid-operation aborts immediately. No done pulse is produced for the aborted op.
- Counter width: $clog2(N)+1.

Optional Feature:
ALU_SDIV_EN
- Defined: opcode 1011 = SDIV, latency N+1.
  - Signed divide by magnitude division plus sign fix-up; quotient truncates toward zero.
  - Divide by zero gives 0.
  - Most-negative / -1 gives the most-negative value, overflow=0.
- Not defined: 1011 is an unused opcode (result 0, latency 1); no sign logic is synthesised.

Decomposition:
- alu_pkg:
  - alu_op_t enum with the opcode constants above, including OP_SDIV.
  - alu_state_t enum (IDLE, MUL, DIV, DONE).
  - Function for ADD/SUB flag computation.
- Sub-module alu_divider: iterative restoring divider with start/done, parametrised by N, instantiated by alu_seq.
- Multiplier and FSM stay in alu_seq.

Test Plan:
- ADD a=0xFFFFFFFFFFFFFFFF, b=1 -> result 0, zero=1, carry=1, overflow=0, negative=0; done 1 cycle after start.
- SUB a=0x8000000000000000, b=1 -> result 0x7FFFFFFFFFFFFFFF, overflow=1, carry=1, negative=0.
- MUL a=12345, b=678 -> result 8369910, done exactly 65 cycles after start, busy high throughout; start pulses while busy are ignored.
- UDIV a=100, b=7 -> result 14. UDIV a=5, b=0 -> result 0, zero=1, latency 65.
- Reset mid-op: start MUL, drop reset_n at cycle 20 -> outputs at reset values, no done. After release, AND a=0xF0, b=0x3C -> result 0x30.
- With ALU_SDIV_EN: SDIV a=-100, b=7 -> result -14 (0xFFFFFFFFFFFFFFF2), negative=1. Without the macro: opcode 1011 -> result 0, zero=1, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/state definitions and flag helper for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_PASSB = 4'b0111,
    OP_MUL   = 4'b1000,
    OP_UDIV  = 4'b1010,
    OP_SDIV  = 4'b1011
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_t;

  // SUB is a + ~b + 1, so the effective sign of operand B is inverted.
  function automatic logic addsub_overflow(input logic a_msb, input logic b_msb,
                                           input logic r_msb, input logic sub);
    return (a_msb == (b_msb ^ sub)) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle, N iterations.
module alu_divider #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         done,
  output logic [N-1:0] quotient
);

  localparam int CW = $clog2(N) + 1;

  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  dsr_q, dsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          dz_q, dz_d;
  logic [N:0]    shifted;
  logic [N:0]    trial;
  logic [N-1:0]  quo_step;
  logic [N-1:0]  rem_step;

  always_comb begin
    shifted  = {rem_q, quo_q[N-1]};
    trial    = shifted - {1'b0, dsr_q};
    quo_step = {quo_q[N-2:0], ~trial[N]};
    rem_step = trial[N] ? shifted[N-1:0] : trial[N-1:0];

    rem_d = rem_q;
    quo_d = quo_q;
    dsr_d = dsr_q;
    cnt_d = cnt_q;
    run_d = run_q;
    dz_d  = dz_q;
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dsr_d = divisor;
      cnt_d = CW'(N);
      run_d = 1'b1;
      dz_d  = (divisor == '0);
    end else if (run_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  // Done is raised during the final iteration so the parent can register the value in the same edge.
  assign done     = run_q && (cnt_q == CW'(1));
  assign quotient = dz_q ? '0 : quo_step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      dz_q  <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      dz_q  <= dz_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/busy/done handshake, shift-add multiply and restoring divide.
// Define ALU_SDIV_EN to enable signed divide on opcode 1011.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow
);

  localparam int CW = $clog2(N) + 1;

  alu_state_t    state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  result_q, result_d;
  logic          zero_q, zero_d;
  logic          neg_q, neg_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N:0]    sum;
  logic [N-1:0]  acc_step;
  logic          is_div;
  logic          div_start;
  logic          div_done;
  logic [N-1:0]  div_a, div_b, div_q;
  logic          wr_en;
  logic [N-1:0]  wr_val;
  logic          wr_c, wr_v;
`ifdef ALU_SDIV_EN
  logic          sneg_q, sneg_d;
`endif

  always_comb begin
    if (ALUControl == OP_SUB)
      sum = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    else
      sum = {1'b0, a} + {1'b0, b};
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Signed divide runs the unsigned core on magnitudes and negates afterwards.
  always_comb begin
    div_a  = a;
    div_b  = b;
    is_div = (ALUControl == OP_UDIV);
`ifdef ALU_SDIV_EN
    if (ALUControl == OP_SDIV) begin
      is_div = 1'b1;
      div_a  = a[N-1] ? (~a + 1'b1) : a;
      div_b  = b[N-1] ? (~b + 1'b1) : b;
    end
`endif
  end

  assign div_start = (state_q == ST_IDLE) && start && is_div;

  alu_divider #(.N(N)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (div_a),
    .divisor  (div_b),
    .done     (div_done),
    .quotient (div_q)
  );

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    wr_val   = '0;
    wr_c     = 1'b0;
    wr_v     = 1'b0;
`ifdef ALU_SDIV_EN
    sneg_d   = sneg_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (ALUControl)
            OP_AND: begin
              wr_en  = 1'b1;
              wr_val = a & b;
            end
            OP_OR: begin
              wr_en  = 1'b1;
              wr_val = a | b;
            end
            OP_ADD: begin
              wr_en  = 1'b1;
              wr_val = sum[N-1:0];
              wr_c   = sum[N];
              wr_v   = addsub_overflow(a[N-1], b[N-1], sum[N-1], 1'b0);
            end
            OP_SUB: begin
              wr_en  = 1'b1;
              wr_val = sum[N-1:0];
              wr_c   = sum[N];
              wr_v   = addsub_overflow(a[N-1], b[N-1], sum[N-1], 1'b1);
            end
            OP_PASSB: begin
              wr_en  = 1'b1;
              wr_val = b;
            end
            OP_MUL: begin
              acc_d    = '0;
              mcand_d  = a;
              mplier_d = b;
              cnt_d    = CW'(N);
              busy_d   = 1'b1;
              state_d  = ST_MUL;
            end
            OP_UDIV: begin
              busy_d  = 1'b1;
              state_d = ST_DIV;
`ifdef ALU_SDIV_EN
              sneg_d  = 1'b0;
`endif
            end
`ifdef ALU_SDIV_EN
            OP_SDIV: begin
              busy_d  = 1'b1;
              state_d = ST_DIV;
              sneg_d  = a[N-1] ^ b[N-1];
            end
`endif
            default: begin
              wr_en  = 1'b1;
              wr_val = '0;
            end
          endcase
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          wr_en  = 1'b1;
          wr_val = acc_step;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          wr_en  = 1'b1;
`ifdef ALU_SDIV_EN
          wr_val = sneg_q ? (~div_q + 1'b1) : div_q;
`else
          wr_val = div_q;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (wr_en) begin
      result_d = wr_val;
      zero_d   = (wr_val == '0);
      neg_d    = wr_val[N-1];
      carry_d  = wr_c;
      ovf_d    = wr_v;
      done_d   = 1'b1;
      busy_d   = 1'b0;
      state_d  = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`ifdef ALU_SDIV_EN
      sneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`ifdef ALU_SDIV_EN
      sneg_q   <= sneg_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Table-driven bench for alu_seq plus directed handshake and reset-abort sequences.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int N = 64;
  localparam logic [N-1:0] ONES = {N{1'b1}};
  localparam logic [N-1:0] MSB  = {1'b1, {(N-1){1'b0}}};

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [N-1:0] a, b;
  logic [3:0]   ctl;
  logic         busy, done, zero, negative, carry, overflow;
  logic [N-1:0] result;

  alu_seq #(.N(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .ALUControl (ctl),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .zero       (zero),
    .negative   (negative),
    .carry      (carry),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [N-1:0] va;
    logic [N-1:0] vb;
    logic [N-1:0] res;
    logic [3:0]   zncv;
    int           lat;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] op, input logic [N-1:0] va,
                              input logic [N-1:0] vb, input logic [N-1:0] res,
                              input logic [3:0] zncv, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.va = va; v.vb = vb; v.res = res; v.zncv = zncv; v.lat = lat;
    return v;
  endfunction

  // Launch one op, scramble the inputs after the start edge, wait (bounded) for done.
  task automatic run_op(input logic [3:0] op, input logic [N-1:0] ia, input logic [N-1:0] ib,
                        output logic [N-1:0] r, output logic [3:0] f, output int lat,
                        output int gaps, output logic busy_at_done);
    @(negedge clk);
    ctl = op; a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~ia; b = ~ib ^ 64'd3; ctl = OP_ADD;
    lat = 1; gaps = 0;
    while (!done && lat < 200) begin
      if (!busy) gaps++;
      @(posedge clk);
      #1;
      lat++;
    end
    r = result;
    f = {zero, negative, carry, overflow};
    busy_at_done = busy;
  endtask

  initial begin
    logic [N-1:0] r;
    logic [3:0]   f;
    int           lat, gaps, dones;
    logic         bd;

    reset_n = 1'b0; start = 1'b0; a = '0; b = '0; ctl = '0;

    vecs.push_back(mk("add_wrap",  OP_ADD,   ONES, 64'd1, 64'd0, 4'b1010, 1));
    vecs.push_back(mk("sub_ovf",   OP_SUB,   MSB, 64'd1, ~MSB, 4'b0011, 1));
    vecs.push_back(mk("and",       OP_AND,   64'hF0, 64'h3C, 64'h30, 4'b0000, 1));
    vecs.push_back(mk("or",        OP_OR,    64'hF0, 64'h0F, 64'hFF, 4'b0000, 1));
    vecs.push_back(mk("passb",     OP_PASSB, 64'd5, MSB, MSB, 4'b0100, 1));
    vecs.push_back(mk("sub_borrow",OP_SUB,   64'd5, 64'd7, ONES - 64'd1, 4'b0100, 1));
    vecs.push_back(mk("add_ovf",   OP_ADD,   ~MSB, 64'd1, MSB, 4'b0101, 1));
    vecs.push_back(mk("mul",       OP_MUL,   64'd12345, 64'd678, 64'd8369910, 4'b0000, 65));
    vecs.push_back(mk("mul_neg",   OP_MUL,   ONES, 64'd3, ONES - 64'd2, 4'b0100, 65));
    vecs.push_back(mk("udiv",      OP_UDIV,  64'd100, 64'd7, 64'd14, 4'b0000, 65));
    vecs.push_back(mk("udiv_dz",   OP_UDIV,  64'd5, 64'd0, 64'd0, 4'b1000, 65));
    vecs.push_back(mk("udiv_big",  OP_UDIV,  ONES, 64'd1, ONES, 4'b0100, 65));
    vecs.push_back(mk("udiv_lt",   OP_UDIV,  64'd7, 64'd9, 64'd0, 4'b1000, 65));
    vecs.push_back(mk("unused3",   4'b0011,  64'd3, 64'd4, 64'd0, 4'b1000, 1));
    vecs.push_back(mk("unused15",  4'b1111,  64'd3, 64'd4, 64'd0, 4'b1000, 1));
`ifdef ALU_SDIV_EN
    vecs.push_back(mk("sdiv",      OP_SDIV,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 4'b0100, 65));
    vecs.push_back(mk("sdiv_min",  OP_SDIV,  MSB, ONES, MSB, 4'b0100, 65));
    vecs.push_back(mk("sdiv_negb", OP_SDIV,  64'd7, ONES - 64'd1, ONES - 64'd2, 4'b0100, 65));
    vecs.push_back(mk("sdiv_dz",   OP_SDIV,  ONES, 64'd0, 64'd0, 4'b1000, 65));
`else
    vecs.push_back(mk("op1011",    4'b1011,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'd0, 4'b1000, 1));
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_zncv", 64'({zero, negative, carry, overflow}), 64'b1000);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].va, vecs[i].vb, r, f, lat, gaps, bd);
      $display("[TB] %s op=%b a=%h b=%h -> result=%h zncv=%b lat=%0d",
               vecs[i].name, vecs[i].op, vecs[i].va, vecs[i].vb, r, f, lat);
      check({vecs[i].name, " result"}, r, vecs[i].res);
      check({vecs[i].name, " zncv"}, 64'(f), 64'(vecs[i].zncv));
      check({vecs[i].name, " latency"}, 64'(lat), 64'(vecs[i].lat));
      check({vecs[i].name, " busy_at_done"}, 64'(bd), 64'd0);
      if (vecs[i].lat > 1) check({vecs[i].name, " busy_gaps"}, 64'(gaps), 64'd0);
      @(posedge clk);
      #1;
      check({vecs[i].name, " done_pulse"}, 64'(done), 64'd0);
    end

    // MUL with stray start pulses while busy, then a start during the done cycle.
    @(negedge clk);
    ctl = OP_MUL; a = 64'd12345; b = 64'd678; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1; gaps = 0;
    while (!done && lat < 200) begin
      if (!busy) gaps++;
      @(negedge clk);
      start = (lat == 10 || lat == 30);
      ctl = OP_ADD; a = 64'd1; b = 64'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    $display("[TB] mul_busy_starts result=%h lat=%0d gaps=%0d", result, lat, gaps);
    check("mulbusy result", result, 64'd8369910);
    check("mulbusy latency", 64'(lat), 64'd65);
    check("mulbusy busy_gaps", 64'(gaps), 64'd0);
    start = 1'b1; ctl = OP_AND; a = 64'hFF; b = 64'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    repeat (4) begin
      if (done) dones++;
      @(posedge clk);
      #1;
    end
    $display("[TB] start_in_done dones=%0d result=%h", dones, result);
    check("start_in_done dones", 64'(dones), 64'd0);
    check("start_in_done result", result, 64'd8369910);

    // Reset in the middle of a multiply.
    @(negedge clk);
    ctl = OP_MUL; a = 64'd12345; b = 64'd678; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    $display("[TB] reset_mid_op busy=%b done=%b result=%h zncv=%b", busy, done, result,
             {zero, negative, carry, overflow});
    check("rstmid busy", 64'(busy), 64'd0);
    check("rstmid done", 64'(done), 64'd0);
    check("rstmid result", result, 64'd0);
    check("rstmid zncv", 64'({zero, negative, carry, overflow}), 64'b1000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("rstmid no_done", 64'(dones), 64'd0);
    run_op(OP_AND, 64'hF0, 64'h3C, r, f, lat, gaps, bd);
    $display("[TB] after_reset and result=%h zncv=%b lat=%0d", r, f, lat);
    check("after_reset result", r, 64'h30);
    check("after_reset latency", 64'(lat), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
